branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 163 ++++++++++++++++
 tb/tb_branch_predictor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and an F->D->E prediction pipeline.
// Define BP_STATS_EN to add saturating BranchCount/MispredictCount statistics outputs.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        BranchE,
  input  logic        BranchTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  output logic        PredictTaken,
  output logic [31:0] PredictedTargetF,
  output logic        BranchTaken,
  output logic        PredictTakenE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic        d_taken_q, d_taken_d;
  logic [31:0] d_target_q, d_target_d;
  logic        e_taken_q, e_taken_d;
  logic [31:0] e_target_q, e_target_d;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit;
  logic             br_taken;
  logic             mis_raw;
  logic             unused_pcf_bits;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign unused_pcf_bits = ^PCF[1:0];

  assign f_hit            = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
  assign PredictTaken     = f_hit && !reset;
  assign PredictedTargetF = target_q[f_idx];

  assign br_taken      = BranchE & BranchTakenE;
  assign BranchTaken   = br_taken;
  assign PredictTakenE = e_taken_q & ~reset;

  // Wrong direction, wrong target on a correctly-predicted taken branch, or an alias hit on a non-branch.
  assign mis_raw = (BranchE & (BranchTakenE != e_taken_q)) |
                   (br_taken & e_taken_q & (BranchTargetE != e_target_q)) |
                   (~BranchE & e_taken_q);
  assign MispredictE = mis_raw & ~reset;
  assign RecoverPCE  = br_taken ? BranchTargetE : (PCE + 32'd4);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (BranchE) begin
      if (BranchTakenE) begin
        if (tag_q[e_idx] != e_tag) begin
          ctr_d[e_idx] = 2'b10;
        end else if (ctr_q[e_idx] != 2'b11) begin
          ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
        end
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = BranchTargetE;
      end else if (ctr_q[e_idx] != 2'b00) begin
        ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
      end
    end else if (e_taken_q) begin
      valid_d[e_idx] = 1'b0;
    end
  end

  // StallD outranks FlushD in Decode; Execute only knows FlushE.
  always_comb begin
    d_taken_d  = d_taken_q;
    d_target_d = d_target_q;
    if (!StallD) begin
      if (FlushD) begin
        d_taken_d  = 1'b0;
        d_target_d = '0;
      end else begin
        d_taken_d  = f_hit;
        d_target_d = PredictedTargetF;
      end
    end
    e_taken_d  = FlushE ? 1'b0 : d_taken_q;
    e_target_d = FlushE ? '0 : d_target_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      d_taken_q  <= 1'b0;
      d_target_q <= '0;
      e_taken_q  <= 1'b0;
      e_target_q <= '0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      d_taken_q  <= d_taken_d;
      d_target_q <= d_target_d;
      e_taken_q  <= e_taken_d;
      e_target_q <= e_target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (BranchE && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (MispredictE && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus randomized traffic
// against an abstract table model; expected responses are queued and checked by a monitor.
module tb_branch_predictor;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] pcf, pce, branch_target_e;
  logic        stall_d, flush_d, flush_e, branch_e, branch_taken_e;
  logic        predict_taken, branch_taken, predict_taken_e, mispredict_e;
  logic [31:0] predicted_target_f, recover_pc_e;
`ifdef BP_STATS_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .reset            (reset),
    .PCF              (pcf),
    .StallD           (stall_d),
    .FlushD           (flush_d),
    .FlushE           (flush_e),
    .BranchE          (branch_e),
    .BranchTakenE     (branch_taken_e),
    .PCE              (pce),
    .BranchTargetE    (branch_target_e),
    .PredictTaken     (predict_taken),
    .PredictedTargetF (predicted_target_f),
    .BranchTaken      (branch_taken),
    .PredictTakenE    (predict_taken_e),
    .MispredictE      (mispredict_e),
    .RecoverPCE       (recover_pc_e)
`ifdef BP_STATS_EN
    ,
    .BranchCount      (branch_count),
    .MispredictCount  (mispredict_count)
`endif
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        br_taken;
    logic        taken_e;
    logic        mis;
    logic [31:0] recover;
    logic [31:0] bcount;
    logic [31:0] mcount;
    logic        chk_state;
  } exp_t;

  exp_t exp_q[$];
  int num_checks = 0;
  int num_errors = 0;

  // Reference model: table entries kept as plain values, counter as an integer 0..3
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  bit          m_d_taken, m_e_taken;
  logic [31:0] m_d_target, m_e_target;
  int unsigned m_bcount, m_mcount;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc / (4 * ENTRIES));
  endfunction

  function automatic bit model_lookup(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic bit model_mis();
    if (branch_e && (branch_taken_e != m_e_taken)) return 1'b1;
    if (branch_e && branch_taken_e && m_e_taken && (branch_target_e != m_e_target)) return 1'b1;
    if (!branch_e && m_e_taken) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check_field("PredictTaken", predict_taken, e.taken);
    if (e.taken) check_field("PredictedTargetF", predicted_target_f, e.target);
    check_field("BranchTaken", branch_taken, e.br_taken);
    check_field("PredictTakenE", predict_taken_e, e.taken_e);
    check_field("MispredictE", mispredict_e, e.mis);
    check_field("RecoverPCE", recover_pc_e, e.recover);
`ifdef BP_STATS_EN
    if (e.chk_state) begin
      check_field("BranchCount", branch_count, e.bcount);
      check_field("MispredictCount", mispredict_count, e.mcount);
    end
`endif
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during that cycle
  task automatic applyStimulus(input logic rst, input logic [31:0] pf, input logic sd, input logic fd,
                               input logic fe, input logic br, input logic tk,
                               input logic [31:0] pe, input logic [31:0] tg);
    exp_t e;
    reset = rst; pcf = pf; stall_d = sd; flush_d = fd; flush_e = fe;
    branch_e = br; branch_taken_e = tk; pce = pe; branch_target_e = tg;
    e.taken     = !rst && model_lookup(pf);
    e.target    = m_target[idx_of(pf)];
    e.br_taken  = br && tk;
    e.taken_e   = !rst && m_e_taken;
    e.mis       = !rst && model_mis();
    e.recover   = (br && tk) ? tg : pe + 32'd4;
    e.bcount    = m_bcount;
    e.mcount    = m_mcount;
    e.chk_state = !rst;
    exp_q.push_back(e);
  endtask

  task automatic model_update();
    bit          f_taken;
    logic [31:0] f_target;
    int          i;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
      end
      m_d_taken = 0; m_d_target = 0; m_e_taken = 0; m_e_target = 0;
      m_bcount = 0; m_mcount = 0;
      return;
    end
    f_taken  = model_lookup(pcf);
    f_target = m_target[idx_of(pcf)];
    if (branch_e && m_bcount != 32'hFFFF_FFFF) m_bcount++;
    if (model_mis() && m_mcount != 32'hFFFF_FFFF) m_mcount++;
    i = idx_of(pce);
    if (branch_e) begin
      if (branch_taken_e) begin
        m_ctr[i]    = (m_tag[i] != tag_of(pce)) ? 2 : ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3);
        m_valid[i]  = 1;
        m_tag[i]    = tag_of(pce);
        m_target[i] = branch_target_e;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (m_e_taken) begin
      m_valid[i] = 0;
    end
    m_e_taken  = flush_e ? 1'b0 : m_d_taken;
    m_e_target = flush_e ? 32'h0 : m_d_target;
    if (!stall_d) begin
      m_d_taken  = flush_d ? 1'b0 : f_taken;
      m_d_target = flush_d ? 32'h0 : f_target;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  logic [31:0] pc_pool [8];
  logic [31:0] tgt_pool [4];

  initial begin : stimulus
    pc_pool  = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h500, 32'h504, 32'h13C, 32'hFFFF_FFFC};
    tgt_pool = '{32'h200, 32'h300, 32'h400, 32'h104};
    reset = 1'b1; pcf = '0; pce = '0; branch_target_e = '0;
    stall_d = 0; flush_d = 0; flush_e = 0; branch_e = 0; branch_taken_e = 0;
    @(posedge clk); #1;

    repeat (2) begin applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); advance(); end

    // Cold lookup, first taken resolution, then a trained hit
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("cold_pt", predict_taken, 0); advance();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 1, 32'h100, 32'h200);
    #1 check_field("first_mis", mispredict_e, 1); check_field("first_recover", recover_pc_e, 32'h200); advance();
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("trained_pt", predict_taken, 1); check_field("trained_tgt", predicted_target_f, 32'h200); advance();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0); advance();

    // Predicted-taken branch resolves to a different target
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 1, 32'h100, 32'h300);
    #1 check_field("tgt_pte", predict_taken_e, 1); check_field("tgt_mis", mispredict_e, 1);
    check_field("tgt_recover", recover_pc_e, 32'h300); advance();
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("retarget", predicted_target_f, 32'h300); advance();

    // Alias lookup and alias hit on a non-branch
    applyStimulus(0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("alias_lookup_pt", predict_taken, 0); advance();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 1, 32'h104, 32'h600); advance();
    applyStimulus(0, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("idx1_pt", predict_taken, 1); advance();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0); advance();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 32'h104, 0);
    #1 check_field("alias_mis", mispredict_e, 1); check_field("alias_recover", recover_pc_e, 32'h108); advance();
    applyStimulus(0, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("alias_cleared_pt", predict_taken, 0); advance();

    // Counter saturation at both ends on entry 0x100
    repeat (3) begin applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h100, 0); advance(); end
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("ctr_low_pt", predict_taken, 0); advance();
    repeat (4) begin applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h300); advance(); end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h100, 0); advance();
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("ctr_sat_pt", predict_taken, 1); advance();

    // Stall beats flush in D; FlushE clears E
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 32'h808, 0); advance();
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 32'h808, 0);
    #1 check_field("stall_pte", predict_taken_e, 1); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h808, 0);
    #1 check_field("flushe_pte", predict_taken_e, 0); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h808, 0);
    #1 check_field("held_d_pte", predict_taken_e, 1); advance();

    // Reset in the middle of an in-flight prediction
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("pre_reset_pt", predict_taken, 1); advance();
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("in_reset_pt", predict_taken, 0); check_field("in_reset_mis", mispredict_e, 0); advance();
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #1 check_field("post_reset_pt", predict_taken, 0); check_field("post_reset_pte", predict_taken_e, 0); advance();

    // Randomized traffic over a small PC pool so entries collide and alias
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    pc_pool[$urandom_range(0, 7)],
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    pc_pool[$urandom_range(0, 7)],
                    tgt_pool[$urandom_range(0, 3)]);
      advance();
    end

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      num_checks++;
      num_errors++;
      $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
